apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge.sv | 138 +++++++++++++
 tb/tb_apb_master_bridge.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Turns a simple valid/ready command interface into single APB transfers
// (SETUP -> ACCESS) and returns one response pulse per command. A wait-state
// counter aborts a transfer that stays in ACCESS for TIMEOUT cycles.
//
// Parameters
//   DATA_WIDTH : APB data width in bits (multiple of 8)
//   ADDR_WIDTH : APB address width
//   TIMEOUT    : max ACCESS cycles before abort, 0 = never abort
//
// Ports
//   PCLK_i, PRESET_i        : clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o : command handshake (ready is combinational)
//   cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i : command fields
//   rsp_valid_o, rsp_rdata_o, rsp_err_o              : one-cycle response
//   PADDR_o, PWRITE_o, PWDATA_o, PSTRB_o, PSEL_o, PENABLE_o : APB request
//   PRDATA_i, PREADY_i, PSLVERR_i                    : APB completion
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 16
) (
    input  logic                    PCLK_i,
    input  logic                    PRESET_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [ADDR_WIDTH-1:0]   PADDR_o,
    output logic                    PWRITE_o,
    output logic [DATA_WIDTH-1:0]   PWDATA_o,
    output logic [DATA_WIDTH/8-1:0] PSTRB_o,
    output logic                    PSEL_o,
    output logic                    PENABLE_o,
    input  logic [DATA_WIDTH-1:0]   PRDATA_i,
    input  logic                    PREADY_i,
    input  logic                    PSLVERR_i
);

    // Counter must be able to hold TIMEOUT itself; keep at least one bit
    // when the timeout is disabled.
    localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic [CNT_WIDTH-1:0] wait_next;

    assign wait_next = wait_cnt + CNT_WIDTH'(1);

    // Ready is the only unregistered output so a new command can be taken in
    // the same cycle the previous response is presented. Gating with reset
    // keeps it low while the block is held in reset.
    assign cmd_ready_o = (state == IDLE) && !PRESET_i;

    // NOTE: every state element below uses non-blocking assignments so all
    // registers update together from the values sampled at the clock edge.
    always_ff @(posedge PCLK_i or posedge PRESET_i) begin
        if (PRESET_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            PADDR_o     <= '0;
            PWRITE_o    <= 1'b0;
            PWDATA_o    <= '0;
            PSTRB_o     <= '0;
            PSEL_o      <= 1'b0;
            PENABLE_o   <= 1'b0;
        end else begin
            // Response is a single-cycle pulse; data/err are zero when idle.
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        // Reads drive zero data and strobes on the bus.
                        PADDR_o  <= cmd_addr_i;
                        PWRITE_o <= cmd_write_i;
                        PWDATA_o <= cmd_write_i ? cmd_wdata_i : '0;
                        PSTRB_o  <= cmd_write_i ? cmd_strb_i  : '0;
                        PSEL_o   <= 1'b1;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    PENABLE_o <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ACCESS;
                end

                ACCESS: begin
                    if (PREADY_i) begin
                        PSEL_o      <= 1'b0;
                        PENABLE_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= PSLVERR_i;
                        rsp_rdata_o <= PWRITE_o ? '0 : PRDATA_i;
                        state       <= IDLE;
                    end else if ((TIMEOUT != 0) && (wait_next == CNT_WIDTH'(TIMEOUT))) begin
                        // Slave never answered: abort with an error response.
                        PSEL_o      <= 1'b0;
                        PENABLE_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_next;
                    end
                end

                default: begin
                    PSEL_o    <= 1'b0;
                    PENABLE_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Drives commands into apb_master_bridge while a bench-side memory slave
// answers the APB bus with a planned number of wait states. A transaction-level
// timeline model predicts every output on every cycle; directed transfers pin
// the model with hand-computed values.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int TO = 16;

    logic          PCLK_i = 1'b0;
    logic          PRESET_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_write_i;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_wdata_i;
    logic [3:0]    cmd_strb_i;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic [AW-1:0] PADDR_o;
    logic          PWRITE_o;
    logic [DW-1:0] PWDATA_o;
    logic [3:0]    PSTRB_o;
    logic          PSEL_o;
    logic          PENABLE_o;
    logic [DW-1:0] PRDATA_i = '0;
    logic          PREADY_i = 1'b0;
    logic          PSLVERR_i = 1'b0;

    apb_master_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .PCLK_i(PCLK_i), .PRESET_i(PRESET_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .PADDR_o(PADDR_o), .PWRITE_o(PWRITE_o), .PWDATA_o(PWDATA_o), .PSTRB_o(PSTRB_o),
        .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o),
        .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i)
    );

    always #5 PCLK_i = ~PCLK_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // ---------------- memory slave (environment) ----------------
    logic [31:0] slv_mem [1024];
    int          plan_wait = 0;   // not-ready ACCESS cycles before PREADY
    bit          plan_err  = 1'b0;
    int          acc_cnt   = 0;

    always @(posedge PCLK_i) begin
        #1;
        if (PSEL_o && PENABLE_o) begin
            acc_cnt++;
            if (acc_cnt == plan_wait + 1) begin
                PREADY_i  = 1'b1;
                PRDATA_i  = slv_mem[PADDR_o];
                PSLVERR_i = plan_err;
                if (PWRITE_o && !plan_err)
                    slv_mem[PADDR_o] = merge(slv_mem[PADDR_o], PWDATA_o, PSTRB_o);
            end else begin
                PREADY_i  = 1'b0;
                PRDATA_i  = $urandom;
                PSLVERR_i = 1'($urandom_range(0, 1));
            end
        end else begin
            acc_cnt   = 0;
            PREADY_i  = 1'($urandom_range(0, 1));
            PRDATA_i  = $urandom;
            PSLVERR_i = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- transaction timeline model ----------------
    // After the accepting edge (phase 0) the bus shows SETUP, then n ACCESS
    // cycles (phases 1..n), then the response at phase n+1.
    logic [31:0] model_mem [1024];
    int          cyc = 0;
    bit          active = 1'b0;
    int          start = 0;
    int          exp_n = 0;
    logic [AW-1:0] e_addr;
    logic          e_write;
    logic [DW-1:0] e_wdata;
    logic [3:0]    e_strb;
    logic          e_err;
    logic [DW-1:0] e_rdata;
    bit            just_accepted = 1'b0;

    function automatic bit model_ready();
        if (PRESET_i) return 1'b0;
        return !(active && (cyc - start) <= exp_n);
    endfunction

    function automatic int access_len(input int w);
        return (TO == 0 || w < TO) ? w + 1 : TO;
    endfunction

    task automatic model_reset();
        active  = 1'b0;
        e_addr  = '0;
        e_write = 1'b0;
        e_wdata = '0;
        e_strb  = '0;
        e_err   = 1'b0;
        e_rdata = '0;
    endtask

    task automatic model_accept();
        bit timed_out;
        timed_out = !(TO == 0 || plan_wait < TO);
        active  = 1'b1;
        start   = cyc;
        exp_n   = access_len(plan_wait);
        e_addr  = cmd_addr_i;
        e_write = cmd_write_i;
        e_wdata = cmd_write_i ? cmd_wdata_i : '0;
        e_strb  = cmd_write_i ? cmd_strb_i : '0;
        e_err   = timed_out ? 1'b1 : plan_err;
        e_rdata = (cmd_write_i || timed_out) ? '0 : model_mem[cmd_addr_i];
        if (cmd_write_i && !plan_err && !timed_out)
            model_mem[cmd_addr_i] = merge(model_mem[cmd_addr_i], cmd_wdata_i, cmd_strb_i);
    endtask

    // One clock: the model sees the edge, then inputs may change at +2.
    task automatic do_cycle();
        bit v, rdy;
        v   = cmd_valid_i;
        rdy = model_ready();
        @(posedge PCLK_i);
        cyc++;
        just_accepted = v && rdy;
        if (just_accepted) model_accept();
        #2;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge PCLK_i) begin : compare
        int p;
        bit x_psel, x_pen, x_rdy, x_rsp;
        if (PRESET_i) begin
            check("rst_ready",  cmd_ready_o, 0);
            check("rst_psel",   PSEL_o, 0);
            check("rst_penable", PENABLE_o, 0);
            check("rst_rsp",    rsp_valid_o, 0);
            check("rst_paddr",  PADDR_o, 0);
            check("rst_pwdata", PWDATA_o, 0);
        end else begin
            p = cyc - start;
            x_psel = 0; x_pen = 0; x_rdy = 1; x_rsp = 0;
            if (active) begin
                if (p == 0) begin
                    x_psel = 1; x_rdy = 0;
                end else if (p <= exp_n) begin
                    x_psel = 1; x_pen = 1; x_rdy = 0;
                end else if (p == exp_n + 1) begin
                    x_rsp = 1;
                end
            end
            check("psel",      PSEL_o, x_psel);
            check("penable",   PENABLE_o, x_pen);
            check("cmd_ready", cmd_ready_o, x_rdy);
            check("rsp_valid", rsp_valid_o, x_rsp);
            check("paddr",     PADDR_o, e_addr);
            check("pwrite",    PWRITE_o, e_write);
            check("pwdata",    PWDATA_o, e_wdata);
            check("pstrb",     PSTRB_o, e_strb);
            if (x_rsp) begin
                check("rsp_err",   rsp_err_o, e_err);
                check("rsp_rdata", rsp_rdata_o, e_rdata);
            end
        end
    end

    // ---------------- transaction driver ----------------
    typedef struct {
        int          acc;       // edges until accepted
        int          lat;       // edges from accept to response
        int          pen;       // cycles PENABLE was seen high
        logic [31:0] rdata;
        logic        err;
        logic        rsp_psel;
        logic        s_psel;
        logic        s_pen;
        logic [9:0]  s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_strb;
    } obs_t;

    task automatic issue(input bit wr, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int w, input bit e, output obs_t o);
        bit got;
        o = '{default: 0};
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a;
        cmd_wdata_i = d;    cmd_strb_i  = s;
        plan_wait   = w;    plan_err    = e;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            do_cycle();
            o.acc++;
            got = just_accepted;
        end
        cmd_valid_i = 1'b0;
        check("accepted", got, 1);
        if (!got) return;
        o.s_psel = PSEL_o; o.s_pen = PENABLE_o; o.s_addr = PADDR_o;
        o.s_wdata = PWDATA_o; o.s_strb = PSTRB_o;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            do_cycle();
            o.lat++;
            if (PENABLE_o) o.pen++;
            if (rsp_valid_o) begin
                got = 1'b1;
                o.rdata = rsp_rdata_o; o.err = rsp_err_o; o.rsp_psel = PSEL_o;
                cmd_valid_i = 1'b0;
            end else if (!model_ready() && $urandom_range(0, 2) == 0) begin
                // Commands offered while busy must be ignored.
                cmd_valid_i = 1'b1; cmd_write_i = 1'($urandom_range(0, 1));
                cmd_addr_i = 10'($urandom); cmd_wdata_i = $urandom; cmd_strb_i = 4'($urandom);
            end else begin
                cmd_valid_i = 1'b0;
            end
        end
        cmd_valid_i = 1'b0;
        check("responded", got, 1);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        obs_t        o;
        logic [31:0] init9;
        bit          got;
        PRESET_i = 1'b1;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
        cmd_wdata_i = '0;   cmd_strb_i  = '0;
        for (int i = 0; i < 1024; i++) begin
            slv_mem[i]   = $urandom;
            model_mem[i] = slv_mem[i];
        end
        slv_mem[5] = 32'h1234_5678; model_mem[5] = 32'h1234_5678;
        init9 = slv_mem[9];
        model_reset();

        #1;
        check("init_ready", cmd_ready_o, 0);
        check("init_rsp",   rsp_valid_o, 0);
        check("init_psel",  PSEL_o, 0);
        repeat (3) do_cycle();
        PRESET_i = 1'b0;
        do_cycle();

        // Read with three wait states: PENABLE for 4 cycles, zero strobes/data.
        issue(0, 10'h005, 32'hFFFF_FFFF, 4'hF, 3, 0, o);
        check("rd_pen_cycles", o.pen, 4);
        check("rd_strb",       o.s_strb, 0);
        check("rd_wdata",      o.s_wdata, 0);
        check("rd_rdata",      o.rdata, 32'h1234_5678);
        check("rd_latency",    o.lat, 5);

        // Zero-wait write: response seen after edge T+2, i.e. in cycle T+3.
        issue(1, 10'h005, 32'hDEAD_BEEF, 4'hF, 0, 0, o);
        check("wr_setup_psel", o.s_psel, 1);
        check("wr_setup_pen",  o.s_pen, 0);
        check("wr_setup_addr", o.s_addr, 10'h005);
        check("wr_setup_data", o.s_wdata, 32'hDEAD_BEEF);
        check("wr_setup_strb", o.s_strb, 4'hF);
        check("wr_latency",    o.lat, 2);
        check("wr_err",        o.err, 0);
        check("wr_rdata",      o.rdata, 0);
        issue(0, 10'h005, 32'h0, 4'h0, 1, 0, o);
        check("rd_back",       o.rdata, 32'hDEAD_BEEF);

        // Slave error, then back-to-back command in the response cycle.
        issue(1, 10'h009, 32'h0BAD_F00D, 4'hF, 2, 1, o);
        check("err_flag",      o.err, 1);
        check("b2b_rsp",       rsp_valid_o, 1);
        check("b2b_ready",     cmd_ready_o, 1);
        issue(0, 10'h009, 32'h0, 4'h0, 0, 0, o);
        check("b2b_accept",    o.acc, 1);
        check("err_no_write",  o.rdata, init9);

        // Timeout boundary: 15 waits completes, slave never ready aborts.
        issue(1, 10'h008, 32'hCAFE_0008, 4'hF, 15, 0, o);
        check("w15_pen",       o.pen, 16);
        check("w15_err",       o.err, 0);
        issue(0, 10'h007, 32'h0, 4'h0, 100, 0, o);
        check("to_pen",        o.pen, 16);
        check("to_latency",    o.lat, 17);
        check("to_err",        o.err, 1);
        check("to_rdata",      o.rdata, 0);
        check("to_psel",       o.rsp_psel, 0);
        issue(0, 10'h008, 32'h0, 4'h0, 0, 0, o);
        check("w15_rd",        o.rdata, 32'hCAFE_0008);

        // Reset in the middle of ACCESS.
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 10'h003;
        cmd_wdata_i = 32'h5555_AAAA; cmd_strb_i = 4'hF; plan_wait = 10; plan_err = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            do_cycle();
            got = just_accepted;
        end
        cmd_valid_i = 1'b0;
        check("mid_accepted", got, 1);
        repeat (3) do_cycle();
        PRESET_i = 1'b1;
        model_reset();
        #1;
        check("mid_rst_psel",   PSEL_o, 0);
        check("mid_rst_pen",    PENABLE_o, 0);
        check("mid_rst_ready",  cmd_ready_o, 0);
        check("mid_rst_rsp",    rsp_valid_o, 0);
        check("mid_rst_paddr",  PADDR_o, 0);
        check("mid_rst_pwdata", PWDATA_o, 0);
        check("mid_rst_pstrb",  PSTRB_o, 0);
        check("mid_rst_pwrite", PWRITE_o, 0);
        repeat (2) do_cycle();
        PRESET_i = 1'b0;
        do_cycle();
        issue(1, 10'h3FF, 32'hA5A5_5A5A, 4'hF, 1, 0, o);
        check("top_wr_err", o.err, 0);
        issue(0, 10'h3FF, 32'h0, 4'h0, 2, 0, o);
        check("top_rd",     o.rdata, 32'hA5A5_5A5A);
        issue(1, 10'h3FF, 32'h1111_2222, 4'h3, 0, 0, o);
        issue(0, 10'h3FF, 32'h0, 4'h0, 0, 0, o);
        check("top_strb_rd", o.rdata, 32'hA5A5_2222);

        // Randomized traffic against the model.
        for (int t = 0; t < 150; t++) begin
            bit          wr, er;
            logic [9:0]  a;
            int          w, r;
            repeat ($urandom_range(0, 2)) do_cycle();
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
            r  = $urandom_range(0, 19);
            w  = (r < 15) ? $urandom_range(0, 3) : (r < 17) ? 15 : (r < 19) ? 16 : 20;
            er = ($urandom_range(0, 7) == 0);
            issue(wr, a, $urandom, 4'($urandom), w, er, o);
            check("rand_pen", o.pen, access_len(w));
        end
        repeat (3) do_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
